// File: rtl/stack_pkg.sv
// Shared constants and state encoding for the stack pointer/flag controller.
package stack_pkg;

  localparam int DEPTH   = 8;
  localparam int ADDR_W  = 3;
  localparam int COUNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } stackState_e;

endpackage

// File: rtl/stack_ctrl.sv
// Pointer, occupancy and error-flag controller that drives the write/read
// enables and top-of-stack address of the sibling stack memory.
module stack_ctrl
  import stack_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               PushReq,
  input  logic               PopReq,
  output logic               PushEnbl,
  output logic               PopEnbl,
  output logic [ADDR_W-1:0]  TOS,
  output logic               Stack_Full,
  output logic               Stack_Empty,
  output logic [COUNT_W-1:0] Count,
  output logic               PopValid,
  output logic               Overflow,
  output logic               Underflow
);

  stackState_e        state_q, state_d;
  logic [ADDR_W-1:0]  tos_q, tos_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               popValid_q, popValid_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic               pushGrant, popGrant;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= EMPTY;
      tos_q       <= '0;
      count_q     <= '0;
      popValid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tos_q       <= tos_d;
      count_q     <= count_d;
      popValid_q  <= popValid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Pop wins a tie, except when empty where only the push can make progress.
  always_comb begin
    popGrant    = PopReq && (state_q != EMPTY);
    pushGrant   = PushReq && ((state_q == EMPTY) || ((state_q == ACTIVE) && !PopReq));
    state_d     = state_q;
    tos_d       = tos_q;
    count_d     = count_q;
    popValid_d  = popGrant;
    overflow_d  = overflow_q || (PushReq && !PopReq && (state_q == FULL));
    underflow_d = underflow_q || (PopReq && !PushReq && (state_q == EMPTY));

    if (pushGrant) begin
      count_d = count_q + COUNT_W'(1);
      if (count_q == COUNT_W'(DEPTH - 1)) begin
        state_d = FULL;
      end else begin
        tos_d   = tos_q + ADDR_W'(1);
        state_d = ACTIVE;
      end
    end else if (popGrant) begin
      count_d = count_q - COUNT_W'(1);
      // While full the pointer already sits on the last written slot.
      if (state_q != FULL) begin
        tos_d = tos_q - ADDR_W'(1);
      end
      state_d = (count_q == COUNT_W'(1)) ? EMPTY : ACTIVE;
    end
  end

  assign PushEnbl    = pushGrant;
  assign PopEnbl     = popGrant;
  assign TOS         = tos_q;
  assign Count       = count_q;
  assign Stack_Full  = (state_q == FULL);
  assign Stack_Empty = (state_q == EMPTY);
  assign PopValid    = popValid_q;
  assign Overflow    = overflow_q;
  assign Underflow   = underflow_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl: directed scenarios followed by random
// push/pop traffic, compared against a queue-based stack model.
module tb_stack_ctrl;
  import stack_pkg::*;

  logic               Clk;
  logic               Reset;
  logic               PushReq;
  logic               PopReq;
  logic               PushEnbl;
  logic               PopEnbl;
  logic [ADDR_W-1:0]  TOS;
  logic               Stack_Full;
  logic               Stack_Empty;
  logic [COUNT_W-1:0] Count;
  logic               PopValid;
  logic               Overflow;
  logic               Underflow;

  logic [7:0]         pushData;
  logic [7:0]         popDataOut;
  logic [7:0]         memModel [DEPTH];
  logic [ADDR_W-1:0]  rdAddr;

  int                 checks = 0;
  int                 errors = 0;

  int                 modelCount;
  logic [7:0]         modelStack [$];
  bit                 modelOvf;
  bit                 modelUnf;
  bit                 expPopValid;
  logic [7:0]         expPopData;

  stack_ctrl dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .PushReq     (PushReq),
    .PopReq      (PopReq),
    .PushEnbl    (PushEnbl),
    .PopEnbl     (PopEnbl),
    .TOS         (TOS),
    .Stack_Full  (Stack_Full),
    .Stack_Empty (Stack_Empty),
    .Count       (Count),
    .PopValid    (PopValid),
    .Overflow    (Overflow),
    .Underflow   (Underflow)
  );

  always #5 Clk = ~Clk;

  // Stand-in for the sibling stack memory: write at TOS, read the top slot.
  assign rdAddr = Stack_Full ? TOS : TOS - ADDR_W'(1);

  always @(posedge Clk) begin
    if (PushEnbl) memModel[TOS] <= pushData;
    if (PopEnbl) popDataOut <= memModel[rdAddr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    modelCount  = 0;
    modelStack.delete();
    modelOvf    = 0;
    modelUnf    = 0;
    expPopValid = 0;
  endtask

  task automatic checkState();
    checkOutput("TOS", 32'(TOS), (modelCount == DEPTH) ? DEPTH - 1 : modelCount);
    checkOutput("Count", 32'(Count), modelCount);
    checkOutput("Stack_Full", 32'(Stack_Full), 32'(modelCount == DEPTH));
    checkOutput("Stack_Empty", 32'(Stack_Empty), 32'(modelCount == 0));
    checkOutput("PopValid", 32'(PopValid), 32'(expPopValid));
    checkOutput("Overflow", 32'(Overflow), 32'(modelOvf));
    checkOutput("Underflow", 32'(Underflow), 32'(modelUnf));
    checkOutput("invCount", 32'(Count), 32'(TOS) + 32'(Stack_Full));
    if (expPopValid) checkOutput("PopDataOut", 32'(popDataOut), 32'(expPopData));
  endtask

  // One clock cycle of requests: check grants mid-cycle, state after the edge.
  task automatic applyStimulus(input bit push, input bit pop, input logic [7:0] data);
    bit expPush, expPop;
    @(negedge Clk);
    PushReq  = push;
    PopReq   = pop;
    pushData = data;
    #1;
    expPush = push && (modelCount < DEPTH) && (!pop || modelCount == 0);
    expPop  = pop && (modelCount > 0);
    checkOutput("PushEnbl", 32'(PushEnbl), 32'(expPush));
    checkOutput("PopEnbl", 32'(PopEnbl), 32'(expPop));
    checkOutput("grantExcl", 32'(PushEnbl && PopEnbl), 32'(0));
    if (push && !pop && modelCount == DEPTH) modelOvf = 1;
    if (pop && !push && modelCount == 0) modelUnf = 1;
    if (expPush) begin
      modelStack.push_back(data);
      modelCount++;
    end else if (expPop) begin
      expPopData = modelStack.pop_back();
      modelCount--;
    end
    expPopValid = expPop;
    @(posedge Clk);
    #1;
    checkState();
  endtask

  initial begin
    Clk      = 1'b0;
    Reset    = 1'b1;
    PushReq  = 1'b0;
    PopReq   = 1'b0;
    pushData = '0;
    resetModel();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    checkState();

    $display("[TB] reset then idle");
    repeat (2) applyStimulus(0, 0, 8'h00);

    $display("[TB] fill, overflow, drain");
    for (int i = 1; i <= DEPTH; i++) applyStimulus(1, 0, 8'(i));
    applyStimulus(1, 0, 8'hAA);
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 8'h00);
    applyStimulus(0, 0, 8'h00);

    $display("[TB] underflow on empty");
    applyStimulus(0, 1, 8'h00);
    applyStimulus(0, 0, 8'h00);

    $display("[TB] simultaneous requests");
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 8'(8'h30 + i));
    applyStimulus(1, 1, 8'h55);
    applyStimulus(0, 1, 8'h00);
    applyStimulus(0, 1, 8'h00);
    applyStimulus(1, 1, 8'h66);
    applyStimulus(0, 1, 8'h00);

    $display("[TB] reset during a pop");
    applyStimulus(1, 0, 8'h77);
    applyStimulus(1, 0, 8'h78);
    @(negedge Clk);
    PushReq = 1'b0;
    PopReq  = 1'b1;
    #1;
    checkOutput("midPopEnbl", 32'(PopEnbl), 32'(1));
    #2;
    Reset = 1'b1;
    resetModel();
    #1;
    PopReq = 1'b0;
    checkState();
    @(posedge Clk);
    #1;
    checkState();
    @(negedge Clk);
    Reset = 1'b0;
    applyStimulus(0, 0, 8'h00);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      int pushPct;
      pushPct = ((i / 50) % 2 == 0) ? 70 : 30;
      applyStimulus($urandom_range(0, 99) < pushPct, $urandom_range(0, 99) < (100 - pushPct),
                    8'($urandom_range(0, 255)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
